// File: rtl/inv_sub_bytes_seq.sv
`timescale 1ns/1ps
// Iterative AES InvSubBytes: latches one 128-bit state and substitutes
// BYTES_PER_CYCLE bytes per clock through the inverse S-box, in place.
module inv_sub_bytes_seq #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] data_out,
  output logic         busy
);

  localparam int STEPS = 16 / BYTES_PER_CYCLE;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
      BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_param
    $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // FIPS-197 inverse S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] INV_SBOX_TABLE = {
    128'h52096ad5_3036a538_bf40a39e_81f3d7fb,
    128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
    128'h547b9432_a6c2233d_ee4c950b_42fac34e,
    128'h082ea166_28d924b2_765ba249_6d8bd125,
    128'h72f8f664_86689816_d4a45ccc_5d65b692,
    128'h6c704850_fdedb9da_5e154657_a78d9d84,
    128'h90d8ab00_8cbcd30a_f7e45805_b8b34506,
    128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
    128'h3a911141_4f67dcea_97f2cfce_f0b4e673,
    128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
    128'h47f11a71_1d29c589_6fb7620e_aa18be1b,
    128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
    128'h1fdda833_8807c731_b1125910_2780ec5f,
    128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
    128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961,
    128'h172b047e_ba77d626_e1691463_55210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX_TABLE[8*(255 - int'(x)) +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [0:127]       buffer;
  logic [CNT_W-1:0]   cnt;
  logic               last_step;

  assign last_step = (cnt == CNT_W'(STEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = BUSY;
      BUSY:    if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Each BUSY cycle rewrites the next group of bytes with its inverse S-box value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buffer <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            buffer <= data_in;
            cnt    <= '0;
          end
        end
        BUSY: begin
          for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            buffer[8*(int'(cnt)*BYTES_PER_CYCLE + j) +: 8] <=
              inv_sbox(buffer[8*(int'(cnt)*BYTES_PER_CYCLE + j) +: 8]);
          end
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    data_out  = '0;
    case (state)
      IDLE: in_ready = 1'b1;
      BUSY: busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        data_out  = buffer;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
`timescale 1ns/1ps
// Scoreboard bench for inv_sub_bytes_seq: default instance plus one
// instance per other legal BYTES_PER_CYCLE for latency checks.
module tb_inv_sub_bytes_seq;

  localparam logic [0:127] ZERO_IN  = 128'h63636363_63636363_63636363_63636363;
  localparam logic [0:127] SEQ_IN   = 128'h00010203_04050607_08090A0B_0C0D0E0F;
  localparam logic [0:127] SEQ_EXP  = 128'h52096AD5_3036A538_BF40A39E_81F3D7FB;
  localparam logic [0:127] RT_IN    = 128'h638293C3_1BFC33F5_C4EEACEA_4BC12816;
  localparam logic [0:127] RT_EXP   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [0:127] MIX_IN   = 128'h637C00ED_16637C00_ED16637C_00ED1663;
  localparam logic [0:127] MIX_EXP  = 128'h00015253_FF000152_53FF0001_5253FF00;
  localparam logic [0:127] ED_IN    = 128'hEDEDEDED_EDEDEDED_EDEDEDED_EDEDEDED;
  localparam logic [0:127] ED_EXP   = 128'h53535353_53535353_53535353_53535353;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] data_out;
  logic         busy;

  logic [3:0]   p_in_ready;
  logic [3:0]   p_out_valid;
  logic [3:0]   p_busy;
  logic [0:127] p_data_out [4];

  int n_vec  = 0;
  int n_miss = 0;
  logic [0:127] exp_q [$];

  always #5 clk = ~clk;

  inv_sub_bytes_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .busy(busy)
  );

  for (genvar g = 0; g < 4; g++) begin : g_par
    localparam int P = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
    inv_sub_bytes_seq #(.BYTES_PER_CYCLE(P)) u_p (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(p_in_ready[g]),
      .data_in(data_in), .out_valid(p_out_valid[g]), .out_ready(out_ready),
      .data_out(p_data_out[g]), .busy(p_busy[g])
    );
  end

  // Counts falling edges after the accept edge until out_valid, capped.
  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; data_in = '0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || data_out !== '0) begin
      n_miss++;
      $display("[TB] FAIL reset_state: got rdy=%b vld=%b busy=%b out=%h required 1 0 0 0",
               in_ready, out_valid, busy, data_out);
    end
    rst_n = 1'b1;
    out_ready = 1'b0;
    in_valid = 1'b1; data_in = ZERO_IN;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_miss++;
      $display("[TB] FAIL pre_reset_done: got vld=%b required 1", out_valid);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || data_out !== '0) begin
      n_miss++;
      $display("[TB] FAIL async_reset: got rdy=%b vld=%b busy=%b out=%h required 1 0 0 0",
               in_ready, out_valid, busy, data_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic test_basic;
    logic [0:127] vin [2];
    logic [0:127] vexp [2];
    logic [0:127] e;
    int lat;
    vin[0] = ZERO_IN; vexp[0] = '0;
    vin[1] = SEQ_IN;  vexp[1] = SEQ_EXP;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; data_in = vin[i];
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_miss++;
        $display("[TB] FAIL basic_in_ready[%0d]: got %b required 1", i, in_ready);
      end
      exp_q.push_back(vexp[i]);
      @(negedge clk);
      in_valid = 1'b0; data_in = {$urandom, $urandom, $urandom, $urandom};
      n_vec++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        n_miss++;
        $display("[TB] FAIL basic_busy[%0d]: got busy=%b rdy=%b required 1 0", i, busy, in_ready);
      end
      wait_out(lat);
      n_vec++;
      if (lat != 4) begin
        n_miss++;
        $display("[TB] FAIL basic_latency[%0d]: got %0d required 4", i, lat);
      end
      e = exp_q.pop_front();
      n_vec++;
      if (data_out !== e) begin
        n_miss++;
        $display("[TB] FAIL basic_data[%0d]: got %h required %h", i, data_out, e);
      end
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_miss++;
        $display("[TB] FAIL basic_idle[%0d]: got vld=%b rdy=%b required 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_params;
    int exp_lat [4];
    int plat [4];
    logic [0:127] pdat [4];
    logic [0:127] e;
    exp_lat = '{16, 8, 2, 1};
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; data_in = RT_IN;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(RT_EXP);
      plat[i] = -1;
      pdat[i] = '0;
    end
    @(negedge clk);
    in_valid = 1'b0; data_in = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (p_out_valid[i] === 1'b1 && plat[i] < 0) begin
          plat[i] = c;
          pdat[i] = p_data_out[i];
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (plat[i] != exp_lat[i]) begin
        n_miss++;
        $display("[TB] FAIL param_latency[%0d]: got %0d required %0d", i, plat[i], exp_lat[i]);
      end
      e = exp_q.pop_front();
      n_vec++;
      if (pdat[i] !== e) begin
        n_miss++;
        $display("[TB] FAIL param_data[%0d]: got %h required %h", i, pdat[i], e);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [0:127] vin [3];
    logic [0:127] vexp [3];
    logic [0:127] e;
    int k, popped, cyc, last_acc;
    logic acc;
    vin[0] = MIX_IN; vexp[0] = MIX_EXP;
    vin[1] = SEQ_IN; vexp[1] = SEQ_EXP;
    vin[2] = RT_IN;  vexp[2] = RT_EXP;
    k = 0; popped = 0; cyc = 0; last_acc = -1;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; data_in = vin[0];
    while ((k < 3 || popped < 3) && cyc < 80) begin
      acc = in_valid && in_ready;
      if (acc) exp_q.push_back(vexp[k]);
      if (out_valid === 1'b1) begin
        e = exp_q.pop_front();
        popped++;
        n_vec++;
        if (data_out !== e) begin
          n_miss++;
          $display("[TB] FAIL b2b_data[%0d]: got %h required %h", popped - 1, data_out, e);
        end
      end
      @(negedge clk);
      cyc++;
      if (acc) begin
        if (last_acc >= 0) begin
          n_vec++;
          if (cyc - last_acc != 6) begin
            n_miss++;
            $display("[TB] FAIL b2b_spacing[%0d]: got %0d required 6", k, cyc - last_acc);
          end
        end
        last_acc = cyc;
        k++;
        if (k == 3) in_valid = 1'b0;
        else        data_in = vin[k];
      end
    end
    n_vec++;
    if (popped != 3) begin
      n_miss++;
      $display("[TB] FAIL b2b_count: got %0d results required 3", popped);
    end
  endtask

  task automatic test_backpressure;
    logic [0:127] e;
    int lat;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; data_in = MIX_IN;
    exp_q.push_back(MIX_EXP);
    @(negedge clk);
    data_in = ~MIX_IN;
    wait_out(lat);
    n_vec++;
    if (lat != 4) begin
      n_miss++;
      $display("[TB] FAIL bp_latency: got %0d required 4", lat);
    end
    e = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || data_out !== e) begin
        n_miss++;
        $display("[TB] FAIL bp_hold[%0d]: got vld=%b rdy=%b out=%h required 1 0 %h",
                 i, out_valid, in_ready, data_out, e);
      end
      @(negedge clk);
      in_valid = 1'b1; data_in = {$urandom, $urandom, $urandom, $urandom};
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL bp_release: got vld=%b rdy=%b busy=%b required 0 1 0",
               out_valid, in_ready, busy);
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_miss++;
      $display("[TB] FAIL bp_single: got vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_busy;
    logic [0:127] e;
    logic stale;
    int lat;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; data_in = SEQ_IN;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== '0) begin
      n_miss++;
      $display("[TB] FAIL mid_reset: got busy=%b vld=%b rdy=%b out=%h required 0 0 1 0",
               busy, out_valid, in_ready, data_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    n_vec++;
    if (stale) begin
      n_miss++;
      $display("[TB] FAIL mid_reset_stale: got out_valid seen=1 required 0");
    end
    in_valid = 1'b1; data_in = ED_IN;
    exp_q.push_back(ED_EXP);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    n_vec++;
    if (lat != 4) begin
      n_miss++;
      $display("[TB] FAIL mid_reset_latency: got %0d required 4", lat);
    end
    e = exp_q.pop_front();
    n_vec++;
    if (data_out !== e) begin
      n_miss++;
      $display("[TB] FAIL mid_reset_data: got %h required %h", data_out, e);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_params();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
